// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (CPU/DMA) round-robin arbiter for a shared memory port
// A transaction is latched at grant, runs ACCESS_CYCLES on the memory, then acks for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  cpu_grants,
  output logic [CNT_W-1:0]  dma_grants
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_dma_q, last_dma_d;
  logic                win_dma_q, win_dma_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic [CNT_W-1:0]    cpu_grants_q, cpu_grants_d;
  logic [CNT_W-1:0]    dma_grants_q, dma_grants_d;
  logic                grant_dma;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_dma_q   <= 1'b1;
      win_dma_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_grants_q <= '0;
      dma_grants_q <= '0;
    end else begin
      state_q      <= state_d;
      last_dma_q   <= last_dma_d;
      win_dma_q    <= win_dma_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_grants_q <= cpu_grants_d;
      dma_grants_q <= dma_grants_d;
    end
  end

  // On a tie the port that did not win last time gets the grant.
  assign grant_dma = dma_req & (~cpu_req | ~last_dma_q);

  always_comb begin
    state_d      = state_q;
    last_dma_d   = last_dma_q;
    win_dma_d    = win_dma_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_grants_d = cpu_grants_q;
    dma_grants_d = dma_grants_q;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req | dma_req) begin
          win_dma_d  = grant_dma;
          last_dma_d = grant_dma;
          we_d       = grant_dma ? dma_we    : cpu_we;
          addr_d     = grant_dma ? dma_addr  : cpu_addr;
          wdata_d    = grant_dma ? dma_wdata : cpu_wdata;
          cnt_d      = CNT_LOAD;
          state_d    = S_ACCESS;
          if (grant_dma) begin
            if (dma_grants_q != {CNT_W{1'b1}}) dma_grants_d = dma_grants_q + 1'b1;
          end else begin
            if (cpu_grants_q != {CNT_W{1'b1}}) cpu_grants_d = cpu_grants_q + 1'b1;
          end
        end
      end
      S_ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = ~we_q;
        // Write strobe only on the final access cycle, so one write edge per transaction.
        mem_write = we_q & (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (win_dma_q) dma_rdata_d = mem_rdata;
            else           cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_ack    = (state_q == S_RESP) & ~win_dma_q;
  assign dma_ack    = (state_q == S_RESP) &  win_dma_q;
  assign cpu_stall  = cpu_req & ~cpu_ack;
  assign busy       = (state_q != S_IDLE);
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_grants = cpu_grants_q;
  assign dma_grants = dma_grants_q;

endmodule
